trace_recorder: RTL and testbench

On-chip retirement trace recorder for the CPU on `mother_board`. It captures (pc, instruction) pairs into a parametrised circular buffer, and can stop on buffer-full or on a trigger opcode. After capture it streams the buffer out as bytes over a valid/ready port toward the UART transmitter. It replaces simulation-only trace printing with a trace that runs on the board, with selectable depth, post-trigger window and trigger mode.

---
 rtl/trace_recorder_pkg.sv | 37 +++
 rtl/trace_ram.sv | 37 +++
 rtl/trace_recorder.sv | 221 ++++++++++++++++++++++
 tb/tb_trace_recorder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_recorder_pkg.sv
// ---------------------------------------------------------------------------
// lib_trace
//   Shared types for the retirement trace recorder.
//   TRACE_STATE : recorder FSM states
//   TRACE_ENTRY : one captured retirement, {pc, inst}
//   ENTRY_BYTES : bytes streamed out per entry
//   entry_byte  : selects dump byte 0..7 of an entry (pc bytes first, LSB first)
// ---------------------------------------------------------------------------
package lib_trace;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DUMP    = 2'd3
    } TRACE_STATE;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } TRACE_ENTRY;

    localparam int ENTRY_BYTES = 8;

    // Bytes 0..3 walk the pc from its low byte upward, bytes 4..7 do the
    // same for the instruction word.
    function automatic logic [7:0] entry_byte(input TRACE_ENTRY e, input logic [2:0] idx);
        logic [7:0] b;
        if (idx[2] == 1'b0) begin
            b = e.pc[{idx[1:0], 3'b000} +: 8];
        end else begin
            b = e.inst[{idx[1:0], 3'b000} +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
//   DEPTH x TRACE_ENTRY storage for the trace recorder. Synchronous write,
//   combinational (asynchronous) read, contents are not reset.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   entry to write
//     raddr  in   read address
//     rdata  out  entry at raddr
// ---------------------------------------------------------------------------
module trace_ram
    import lib_trace::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  TRACE_ENTRY    wdata,
    input  logic [AW-1:0] raddr,
    output TRACE_ENTRY    rdata
);

    TRACE_ENTRY mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_recorder.sv
// ---------------------------------------------------------------------------
// trace_recorder
//   Captures (pc, instruction) retirement pairs into a circular buffer and,
//   once capture stops (buffer full in mode 0, or POST entries after a
//   trigger opcode in mode 1), streams the buffer out oldest-first as bytes
//   over a valid/ready port.
//   Ports:
//     clk       in   clock
//     reset     in   synchronous, active-high
//     arm       in   start a capture (honoured only when idle)
//     mode      in   0 = stop when full, 1 = circular with trigger
//     trig_op   in   trigger opcode, matched against ret_inst[7:0]
//     ret_valid in   an instruction retired this cycle
//     ret_pc    in   pc of the retired instruction
//     ret_inst  in   raw instruction word
//     tx_valid  out  dump byte available
//     tx_data   out  dump byte
//     tx_ready  in   consumer accepts the byte
//     busy      out  recorder not idle
//     done      out  one-cycle pulse after the last dump byte is accepted
//     count     out  valid entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module trace_recorder
    import lib_trace::*;
#(
    parameter int DEPTH = 16,
    parameter int POST  = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          mode,
    input  logic [7:0]    trig_op,
    input  logic          ret_valid,
    input  logic [31:0]   ret_pc,
    input  logic [31:0]   ret_inst,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    TRACE_STATE    state_q,    state_d;
    logic          mode_q,     mode_d;
    logic [7:0]    trig_op_q,  trig_op_d;
    logic [AW-1:0] wptr_q,     wptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [CW-1:0] left_q,     left_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          done_q,     done_d;

    logic          ram_we;
    TRACE_ENTRY    ram_wdata;
    TRACE_ENTRY    ram_rdata;

    // Values a capturing write would produce this cycle.
    logic [AW-1:0] wr_wptr;
    logic [CW-1:0] wr_count;
    logic          go_dump;

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (ram_wdata),
        .raddr (rptr_d),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        trig_op_d  = trig_op_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        rptr_d     = rptr_q;
        byte_idx_d = byte_idx_q;
        left_d     = left_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = '{pc: ret_pc, inst: ret_inst};
        go_dump    = 1'b0;

        wr_wptr  = wptr_q + AW'(1);
        wr_count = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (arm) begin
                    mode_d     = mode;
                    trig_op_d  = trig_op;
                    count_d    = '0;
                    wptr_d     = '0;
                    post_cnt_d = '0;
                    state_d    = CAPTURE;
                end
            end

            CAPTURE: begin
                if (ret_valid) begin
                    ram_we  = 1'b1;
                    wptr_d  = wr_wptr;
                    count_d = wr_count;
                    if (!mode_q) begin
                        if (wr_count == CW'(DEPTH)) begin
                            go_dump = 1'b1;
                        end
                    end else if (ret_inst[7:0] == trig_op_q) begin
                        if (POST == 0) begin
                            go_dump = 1'b1;
                        end else begin
                            state_d = lib_trace::POST;
                        end
                    end
                end
            end

            lib_trace::POST: begin
                // A trigger opcode seen here is just another entry.
                if (ret_valid) begin
                    ram_we     = 1'b1;
                    wptr_d     = wr_wptr;
                    count_d    = wr_count;
                    post_cnt_d = post_cnt_q + CW'(1);
                    if (post_cnt_d == CW'(POST)) begin
                        go_dump = 1'b1;
                    end
                end
            end

            DUMP: begin
                // First DUMP cycle only loads the byte register; afterwards
                // each handshake steps to the next byte with no bubble.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    if (byte_idx_q == 3'(ENTRY_BYTES - 1)) begin
                        byte_idx_d = '0;
                        rptr_d     = rptr_q + AW'(1);
                        left_d     = left_q - CW'(1);
                        if (left_q == CW'(1)) begin
                            tx_valid_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Oldest entry sits count entries behind the write pointer; when the
        // buffer is full count mod DEPTH is zero and that is wptr itself.
        if (go_dump) begin
            state_d    = DUMP;
            rptr_d     = wr_wptr - wr_count[AW-1:0];
            byte_idx_d = '0;
            left_d     = wr_count;
        end

        // The read address follows the next pointer so the byte register
        // already holds the next byte in the cycle after a handshake.
        tx_data_d = tx_valid_d ? entry_byte(ram_rdata, byte_idx_d) : tx_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            trig_op_q  <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            rptr_q     <= '0;
            byte_idx_q <= '0;
            left_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            trig_op_q  <= trig_op_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            rptr_q     <= rptr_d;
            byte_idx_q <= byte_idx_d;
            left_q     <= left_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_trace_recorder.sv
// ---------------------------------------------------------------------------
// tb_trace_recorder
//   Two DEPTH=4 recorders, one with POST=1 and one with POST=2, share the
//   stimulus; 'sel' picks which one receives arm and whose outputs are
//   observed. Capture phases come from a vector table; dumps are compared
//   byte by byte against expected entries written out by hand.
// ---------------------------------------------------------------------------
module tb_trace_recorder;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        mode;
    logic [7:0]  trig_op;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [31:0] ret_inst;
    logic        tx_ready;
    logic        sel;

    logic        arm_a, arm_b;
    logic        tx_valid_a, tx_valid_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic [2:0]  count_a, count_b;

    logic        tx_valid_m;
    logic [7:0]  tx_data_m;
    logic        busy_m;
    logic        done_m;
    logic [2:0]  count_m;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_pc   [4];
    logic [31:0] exp_inst [4];

    typedef struct packed {
        logic        arm;
        logic        mode;
        logic [7:0]  trig;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exp_busy;
        logic [2:0]  exp_count;
        logic        exp_txv;
    } vec_t;

    vec_t tab[$];

    assign arm_a = arm & ~sel;
    assign arm_b = arm & sel;

    assign tx_valid_m = sel ? tx_valid_b : tx_valid_a;
    assign tx_data_m  = sel ? tx_data_b  : tx_data_a;
    assign busy_m     = sel ? busy_b     : busy_a;
    assign done_m     = sel ? done_b     : done_a;
    assign count_m    = sel ? count_b    : count_a;

    trace_recorder #(.DEPTH(4), .POST(1)) u_dut_p1 (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm_a),
        .mode      (mode),
        .trig_op   (trig_op),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_inst  (ret_inst),
        .tx_valid  (tx_valid_a),
        .tx_data   (tx_data_a),
        .tx_ready  (tx_ready),
        .busy      (busy_a),
        .done      (done_a),
        .count     (count_a)
    );

    trace_recorder #(.DEPTH(4), .POST(2)) u_dut_p2 (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm_b),
        .mode      (mode),
        .trig_op   (trig_op),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_inst  (ret_inst),
        .tx_valid  (tx_valid_b),
        .tx_data   (tx_data_b),
        .tx_ready  (tx_ready),
        .busy      (busy_b),
        .done      (done_b),
        .count     (count_b)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Ordinary instruction word for a pc; low byte 0x13 never matches 0x0A
    function automatic logic [31:0] mkInst(input logic [31:0] pc);
        return {16'hC0DE, pc[7:0], 8'h13};
    endfunction

    function automatic vec_t mkVec(input logic a, input logic m, input logic [7:0] t,
                                   input logic rv, input logic [31:0] pc, input logic [31:0] inst,
                                   input logic eb, input logic [2:0] ec, input logic etx);
        vec_t v;
        v = '{a, m, t, rv, pc, inst, eb, ec, etx};
        return v;
    endfunction

    // Expected k-th dump byte from the hand-written entry list
    function automatic logic [7:0] expByte(input int k);
        logic [31:0] w;
        int e;
        int b;
        e = k / 8;
        b = k % 8;
        w = (b < 4) ? exp_pc[e] : exp_inst[e];
        return w[8*(b%4) +: 8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // One table row: drive at negedge, clock it, sample #1 after the edge
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = tab[idx];
        @(negedge clk);
        arm       = v.arm;
        mode      = v.mode;
        trig_op   = v.trig;
        ret_valid = v.rv;
        ret_pc    = v.pc;
        ret_inst  = v.inst;
        @(posedge clk);
        #1;
        arm       = 1'b0;
        ret_valid = 1'b0;
        checkOutput($sformatf("vec%0d_busy", idx),  {31'd0, busy_m},     {31'd0, v.exp_busy});
        checkOutput($sformatf("vec%0d_count", idx), {29'd0, count_m},    {29'd0, v.exp_count});
        checkOutput($sformatf("vec%0d_txv", idx),   {31'd0, tx_valid_m}, {31'd0, v.exp_txv});
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(i);
        end
    endtask

    task automatic setExp(input int k, input logic [31:0] pc, input logic [31:0] inst);
        exp_pc[k]   = pc;
        exp_inst[k] = inst;
    endtask

    // Drain a dump of n entries; toggle selects the 1,0,0,1 ready pattern
    task automatic runDump(input string tag, input int n, input bit toggle);
        int got;
        int cyc;
        int cyc_v;
        logic [3:0] pat;
        got   = 0;
        cyc   = 0;
        cyc_v = 0;
        pat   = 4'b1001;
        while (got < 8*n && cyc < 64*n + 20) begin
            @(negedge clk);
            tx_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (tx_valid_m) begin
                cyc_v++;
                checkOutput($sformatf("%s_byte%0d", tag, got), {24'd0, tx_data_m}, {24'd0, expByte(got)});
                if (tx_ready) got++;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        tx_ready = 1'b0;
        checkOutput({tag, "_nbytes"}, got, 8*n);
        if (!toggle) checkOutput({tag, "_cycles"}, cyc_v, 8*n);
        checkOutput({tag, "_done"}, {31'd0, done_m},     32'd1);
        checkOutput({tag, "_busy"}, {31'd0, busy_m},     32'd0);
        checkOutput({tag, "_txv"},  {31'd0, tx_valid_m}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_drop"}, {31'd0, done_m}, 32'd0);
        checkOutput({tag, "_count_hold"}, {29'd0, count_m}, n);
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        mode      = 1'b0;
        trig_op   = 8'h00;
        ret_valid = 1'b0;
        ret_pc    = '0;
        ret_inst  = '0;
        tx_ready  = 1'b0;
        sel       = 1'b0;

        // Rows 0..5: mode 0, stop when full, fifth retirement is dropped
        tab.push_back(mkVec(1, 0, 8'h00, 0, 32'h0,   32'h0,               1, 3'd0, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h100, mkInst(32'h100),     1, 3'd1, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h104, mkInst(32'h104),     1, 3'd2, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h108, mkInst(32'h108),     1, 3'd3, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h10C, mkInst(32'h10C),     1, 3'd4, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h110, mkInst(32'h110),     1, 3'd4, 1));
        // Rows 6..13: mode 1, POST=1, trigger on 6th retirement
        tab.push_back(mkVec(1, 1, 8'h0A, 0, 32'h0,   32'h0,               1, 3'd0, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h200, mkInst(32'h200),     1, 3'd1, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h204, mkInst(32'h204),     1, 3'd2, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h208, mkInst(32'h208),     1, 3'd3, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h20C, mkInst(32'h20C),     1, 3'd4, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h210, mkInst(32'h210),     1, 3'd4, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h214, 32'h0000000A,        1, 3'd4, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h218, mkInst(32'h218),     1, 3'd4, 0));
        // Rows 14..20: POST=2 recorder, trigger on 2nd, stray arm, retrigger
        // opcode in POST, stray retirement in DUMP
        tab.push_back(mkVec(1, 1, 8'h0A, 0, 32'h0,   32'h0,               1, 3'd0, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h300, mkInst(32'h300),     1, 3'd1, 0));
        tab.push_back(mkVec(1, 0, 8'hFF, 0, 32'h0,   32'h0,               1, 3'd1, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h304, 32'h0000000A,        1, 3'd2, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h308, 32'h0000010A,        1, 3'd3, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h30C, mkInst(32'h30C),     1, 3'd4, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h3F0, mkInst(32'h3F0),     1, 3'd4, 1));
        // Rows 21..25: mode 0 capture that is reset mid-dump
        tab.push_back(mkVec(1, 0, 8'h00, 0, 32'h0,   32'h0,               1, 3'd0, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h400, mkInst(32'h400),     1, 3'd1, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h404, mkInst(32'h404),     1, 3'd2, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h408, mkInst(32'h408),     1, 3'd3, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h40C, mkInst(32'h40C),     1, 3'd4, 0));
        // Rows 26..30: fresh capture after the reset
        tab.push_back(mkVec(1, 0, 8'h00, 0, 32'h0,   32'h0,               1, 3'd0, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h500, mkInst(32'h500),     1, 3'd1, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h504, mkInst(32'h504),     1, 3'd2, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h508, mkInst(32'h508),     1, 3'd3, 0));
        tab.push_back(mkVec(0, 0, 8'h00, 1, 32'h50C, mkInst(32'h50C),     1, 3'd4, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_txv",   {31'd0, tx_valid_a}, 32'd0);
        checkOutput("rst_txd",   {24'd0, tx_data_a},  32'd0);
        checkOutput("rst_busy",  {31'd0, busy_a},     32'd0);
        checkOutput("rst_done",  {31'd0, done_a},     32'd0);
        checkOutput("rst_count", {29'd0, count_a},    32'd0);
        checkOutput("rst_busy_b", {31'd0, busy_b},    32'd0);
        reset = 1'b0;

        // Mode 0: four entries, fifth dropped
        $display("[TB] mode 0 stop-when-full");
        sel = 1'b0;
        runVectors(0, 5);
        setExp(0, 32'h100, mkInst(32'h100));
        setExp(1, 32'h104, mkInst(32'h104));
        setExp(2, 32'h108, mkInst(32'h108));
        setExp(3, 32'h10C, mkInst(32'h10C));
        runDump("m0", 4, 1'b0);

        // Mode 1 trigger with wrap, drained with a stalling consumer
        $display("[TB] mode 1 POST=1 with ready toggling");
        runVectors(6, 13);
        setExp(0, 32'h20C, mkInst(32'h20C));
        setExp(1, 32'h210, mkInst(32'h210));
        setExp(2, 32'h214, 32'h0000000A);
        setExp(3, 32'h218, mkInst(32'h218));
        runDump("m1p1", 4, 1'b1);

        // POST=2, early trigger, stray arm and stray retirement
        $display("[TB] mode 1 POST=2 early trigger");
        sel = 1'b1;
        runVectors(14, 20);
        setExp(0, 32'h300, mkInst(32'h300));
        setExp(1, 32'h304, 32'h0000000A);
        setExp(2, 32'h308, 32'h0000010A);
        setExp(3, 32'h30C, mkInst(32'h30C));
        runDump("m1p2", 4, 1'b0);

        // Reset on the third dump byte, then a clean capture
        $display("[TB] reset during dump");
        sel = 1'b0;
        runVectors(21, 25);
        setExp(0, 32'h400, mkInst(32'h400));
        setExp(1, 32'h404, mkInst(32'h404));
        setExp(2, 32'h408, mkInst(32'h408));
        setExp(3, 32'h40C, mkInst(32'h40C));
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rd_first_txv", {31'd0, tx_valid_m}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rd_byte%0d", c), {24'd0, tx_data_m}, {24'd0, expByte(c)});
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("rd_byte2_present", {24'd0, tx_data_m}, {24'd0, expByte(2)});
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rd_txv",   {31'd0, tx_valid_m}, 32'd0);
        checkOutput("rd_busy",  {31'd0, busy_m},     32'd0);
        checkOutput("rd_count", {29'd0, count_m},    32'd0);
        checkOutput("rd_done",  {31'd0, done_m},     32'd0);
        checkOutput("rd_txd",   {24'd0, tx_data_m},  32'd0);
        reset    = 1'b0;
        tx_ready = 1'b0;
        runVectors(26, 30);
        setExp(0, 32'h500, mkInst(32'h500));
        setExp(1, 32'h504, mkInst(32'h504));
        setExp(2, 32'h508, mkInst(32'h508));
        setExp(3, 32'h50C, mkInst(32'h50C));
        runDump("rearm", 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
